// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Purpose:
//   Turns a serial stream of note-on / note-off events into per-voice
//   oscillator assignments for an OSC_VOICES-voice polyphonic synth.
//   Each accepted event is handled by a sequential scan over the voices
//   (one voice per clock), followed by a single commit cycle in which the
//   voice table and the outputs are updated.
//
//   Note-on target priority: matching voice (retrigger) > lowest free voice >
//   oldest active voice (steal). Every voice carries an age rank;
//   rank 0 = youngest, rank OSC_VOICES-1 = oldest. The ranks always form a
//   permutation of 0..OSC_VOICES-1.
//
// Optional feature (compile-time macro VOICE_STEAL_EN):
//   defined   : with no match and no free voice, the oldest voice is stolen;
//               overflow_o stays 0.
//   undefined : such a note-on is dropped, overflow_o pulses for one cycle and
//               the voice table is left untouched.
//
// Handshake:
//   An event transfers on a rising clk_i edge where note_valid_i and
//   note_ready_o are both high; note_on_i and note_i are latched on that edge.
//   note_ready_o is high only while the FSM is IDLE. While ready is low the
//   upstream stage keeps valid and the payload stable; nothing is consumed.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous, active-high reset
//   note_valid_i    event valid
//   note_ready_o    allocator can accept an event
//   note_on_i       1 = note-on, 0 = note-off
//   note_i          note number
//   voice_active_o  bit v = voice v sounding (feeds the downstream bitcount)
//   voice_note_o    note of voice v at bits [v*NOTE_W +: NOTE_W]
//   voice_trig_o    one-cycle pulse: voice v (re)started
//   overflow_o      one-cycle pulse: note-on dropped (steal disabled only)
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter  int OSC_VOICES = 7,
  parameter  int NOTE_W     = 7,
  localparam int RANK_W     = $clog2(OSC_VOICES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         note_valid_i,
  output logic                         note_ready_o,
  input  logic                         note_on_i,
  input  logic [NOTE_W-1:0]            note_i,
  output logic [OSC_VOICES-1:0]        voice_active_o,
  output logic [OSC_VOICES*NOTE_W-1:0] voice_note_o,
  output logic [OSC_VOICES-1:0]        voice_trig_o,
  output logic                         overflow_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [RANK_W-1:0] LAST = RANK_W'(OSC_VOICES - 1);

  state_e              state_q, state_d;
  logic [RANK_W-1:0]   idx_q, idx_d;

  // Latched event
  logic                lat_on_q, lat_on_d;
  logic [NOTE_W-1:0]   lat_note_q, lat_note_d;

  // Scan results
  logic                match_hit_q, match_hit_d;
  logic [RANK_W-1:0]   match_idx_q, match_idx_d;
  logic                free_hit_q, free_hit_d;
  logic [RANK_W-1:0]   free_idx_q, free_idx_d;
`ifdef VOICE_STEAL_EN
  logic                old_hit_q, old_hit_d;
  logic [RANK_W-1:0]   old_idx_q, old_idx_d;
`endif

  // Voice table
  logic [OSC_VOICES-1:0] active_q, active_d;
  logic [NOTE_W-1:0]     note_q [OSC_VOICES];
  logic [NOTE_W-1:0]     note_d [OSC_VOICES];
  logic [RANK_W-1:0]     rank_q [OSC_VOICES];
  logic [RANK_W-1:0]     rank_d [OSC_VOICES];

  // Pulse outputs
  logic [OSC_VOICES-1:0] trig_q, trig_d;
  logic                  ovf_q, ovf_d;

  // Commit-cycle target selection
  logic                  take_on;
  logic [RANK_W-1:0]     tgt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lat_on_q    <= 1'b0;
      lat_note_q  <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
`ifdef VOICE_STEAL_EN
      old_hit_q   <= 1'b0;
      old_idx_q   <= '0;
`endif
      active_q    <= '0;
      trig_q      <= '0;
      ovf_q       <= 1'b0;
      for (int v = 0; v < OSC_VOICES; v++) begin
        note_q[v] <= '0;
        rank_q[v] <= RANK_W'(v);
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_on_q    <= lat_on_d;
      lat_note_q  <= lat_note_d;
      match_hit_q <= match_hit_d;
      match_idx_q <= match_idx_d;
      free_hit_q  <= free_hit_d;
      free_idx_q  <= free_idx_d;
`ifdef VOICE_STEAL_EN
      old_hit_q   <= old_hit_d;
      old_idx_q   <= old_idx_d;
`endif
      active_q    <= active_d;
      trig_q      <= trig_d;
      ovf_q       <= ovf_d;
      for (int v = 0; v < OSC_VOICES; v++) begin
        note_q[v] <= note_d[v];
        rank_q[v] <= rank_d[v];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_on_d    = lat_on_q;
    lat_note_d  = lat_note_q;
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
`ifdef VOICE_STEAL_EN
    old_hit_d   = old_hit_q;
    old_idx_d   = old_idx_q;
`endif
    active_d    = active_q;
    for (int v = 0; v < OSC_VOICES; v++) begin
      note_d[v] = note_q[v];
      rank_d[v] = rank_q[v];
    end
    trig_d      = '0;
    ovf_d       = 1'b0;
    take_on     = 1'b0;
    tgt         = '0;

    unique case (state_q)
      IDLE: begin
        if (note_valid_i) begin
          state_d     = SCAN;
          idx_d       = '0;
          lat_on_d    = note_on_i;
          lat_note_d  = note_i;
          match_hit_d = 1'b0;
          free_hit_d  = 1'b0;
`ifdef VOICE_STEAL_EN
          old_hit_d   = 1'b0;
`endif
        end
      end

      SCAN: begin
        // Only the first hit of each kind is kept, so the lowest index wins.
        if (active_q[idx_q] && (note_q[idx_q] == lat_note_q) && !match_hit_q) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!active_q[idx_q] && !free_hit_q) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end
`ifdef VOICE_STEAL_EN
        if (active_q[idx_q] && (rank_q[idx_q] == LAST)) begin
          old_hit_d = 1'b1;
          old_idx_d = idx_q;
        end
`endif
        if (idx_q == LAST) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + RANK_W'(1);
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (lat_on_q) begin
          if (match_hit_q) begin
            take_on = 1'b1;
            tgt     = match_idx_q;
          end else if (free_hit_q) begin
            take_on = 1'b1;
            tgt     = free_idx_q;
          end else begin
`ifdef VOICE_STEAL_EN
            // With no free voice every voice is active, so exactly one
            // carries the oldest rank; old_hit_q is a safety guard only.
            take_on = old_hit_q;
            tgt     = old_idx_q;
`else
            ovf_d   = 1'b1;
`endif
          end

          if (take_on) begin
            active_d[tgt] = 1'b1;
            note_d[tgt]   = lat_note_q;
            trig_d[tgt]   = 1'b1;
            // Move the target to the front of the age list: everything that
            // was younger than it ages by one, older voices keep their rank.
            for (int v = 0; v < OSC_VOICES; v++) begin
              if (RANK_W'(v) == tgt) begin
                rank_d[v] = '0;
              end else if (rank_q[v] < rank_q[tgt]) begin
                rank_d[v] = rank_q[v] + RANK_W'(1);
              end
            end
          end
        end else if (match_hit_q) begin
          // Note-off keeps the note value and the age ranks.
          active_d[match_idx_q] = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign note_ready_o   = (state_q == IDLE);
  assign voice_active_o = active_q;
  assign voice_trig_o   = trig_q;
  assign overflow_o     = ovf_q;

  always_comb begin
    voice_note_o = '0;
    for (int v = 0; v < OSC_VOICES; v++) begin
      voice_note_o[v*NOTE_W +: NOTE_W] = note_q[v];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//
// Directed testbench for voice_allocator (OSC_VOICES = 7, NOTE_W = 7).
// Expected values are hand-computed per vector. Build-dependent expectations
// follow the VOICE_STEAL_EN macro, same as the design.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

  localparam int V  = 7;
  localparam int NW = 7;
  localparam int BUSY = V + 1;   // ready-low cycles per accepted event
  localparam int TMO  = 50;      // bound on any wait for the DUT

  logic            clk;
  logic            rst;
  logic            note_valid;
  logic            note_ready;
  logic            note_on;
  logic [NW-1:0]   note;
  logic [V-1:0]    voice_active;
  logic [V*NW-1:0] voice_note;
  logic [V-1:0]    voice_trig;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-maintained expected voice table
  logic [NW-1:0] exp_note [V];
  logic [V-1:0]  exp_active;

  voice_allocator #(
    .OSC_VOICES(V),
    .NOTE_W    (NW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .note_valid_i  (note_valid),
    .note_ready_o  (note_ready),
    .note_on_i     (note_on),
    .note_i        (note),
    .voice_active_o(voice_active),
    .voice_note_o  (voice_note),
    .voice_trig_o  (voice_trig),
    .overflow_o    (overflow)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [V*NW-1:0] pack_notes();
    logic [V*NW-1:0] w;
    w = '0;
    for (int v = 0; v < V; v++) w[v*NW +: NW] = exp_note[v];
    return w;
  endfunction

  task automatic check_table(input string tag);
    check({tag, "_active"}, 64'(voice_active), 64'(exp_active));
    check({tag, "_notes"},  64'(voice_note),   64'(pack_notes()));
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    note_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_active = '0;
    for (int v = 0; v < V; v++) exp_note[v] = '0;
  endtask

  // Called on a negedge. Presents one event, waits for its acceptance, then
  // watches every negedge until ready returns. When hold is set, valid stays
  // high afterwards so the next call is a back-to-back transfer.
  task automatic send(input logic on, input logic [NW-1:0] n, input logic hold,
                      output logic [V-1:0] trig_or, output int trig_cnt,
                      output int ovf_cnt);
    int wait_cnt;
    int low_cnt;
    logic rdy;
    note_valid = 1'b1;
    note_on    = on;
    note       = n;
    wait_cnt   = 0;
    while (!note_ready && wait_cnt < TMO) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("accept_wait", 64'(wait_cnt), 64'd0);
    @(posedge clk);
    #1;
    if (!hold) note_valid = 1'b0;
    low_cnt  = 0;
    trig_or  = '0;
    trig_cnt = 0;
    ovf_cnt  = 0;
    rdy      = 1'b0;
    while (!rdy && low_cnt < TMO) begin
      @(negedge clk);
      rdy = note_ready;
      if (!rdy) low_cnt++;
      trig_or = trig_or | voice_trig;
      if (voice_trig != '0) trig_cnt++;
      if (overflow) ovf_cnt++;
    end
    check("busy_cycles", 64'(low_cnt), 64'(BUSY));
  endtask

  // Sends a note-on that must land on voice tv with exactly one trig pulse.
  task automatic note_on_to(input logic [NW-1:0] n, input int tv, input logic hold,
                            input string tag);
    logic [V-1:0] t_or;
    int t_cnt, o_cnt;
    send(1'b1, n, hold, t_or, t_cnt, o_cnt);
    check({tag, "_trig"},     64'(t_or),  64'(1) << tv);
    check({tag, "_trig_cnt"}, 64'(t_cnt), 64'd1);
    check({tag, "_ovf"},      64'(o_cnt), 64'd0);
    exp_active[tv] = 1'b1;
    exp_note[tv]   = n;
    check_table(tag);
  endtask

  task automatic fill_60_66();
    for (int i = 0; i < V; i++) begin
      note_on_to(NW'(60 + i), i, (i < V - 1), "fill");
    end
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check({tag, "_trig_clr"}, 64'(voice_trig), 64'd0);
    check({tag, "_ovf_clr"},  64'(overflow),   64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [V-1:0] t_or;
    int t_cnt, o_cnt;

    rst        = 1'b1;
    note_valid = 1'b0;
    note_on    = 1'b0;
    note       = '0;

    // 1. Reset values
    do_reset();
    check("rst_ready",  64'(note_ready),   64'd1);
    check("rst_active", 64'(voice_active), 64'd0);
    check("rst_notes",  64'(voice_note),   64'd0);
    check("rst_trig",   64'(voice_trig),   64'd0);
    check("rst_ovf",    64'(overflow),     64'd0);

    // 2. Single note-on 60 lands on voice 0, trig lasts one cycle
    note_on_to(7'd60, 0, 1'b0, "on60");
    check_quiet("on60");

    // 3. Back-to-back note-ons 60..66 with valid held high
    do_reset();
    fill_60_66();
    check("full_active", 64'(voice_active), 64'h7f);
    check_quiet("full");

    // 4. Table full, note-on 70
`ifdef VOICE_STEAL_EN
    note_on_to(7'd70, 0, 1'b0, "steal70");
    note_on_to(7'd71, 1, 1'b0, "steal71");
    check_quiet("steal");
`else
    send(1'b1, 7'd70, 1'b0, t_or, t_cnt, o_cnt);
    check("drop70_ovf_cnt", 64'(o_cnt), 64'd1);
    check("drop70_trig",    64'(t_or),  64'd0);
    check_table("drop70");
    check_quiet("drop70");
`endif

    // 5. Retrigger 62 on voice 2: no new voice, voice 2 becomes youngest
    do_reset();
    fill_60_66();
    note_on_to(7'd62, 2, 1'b0, "retrig62");
    check("retrig_active", 64'(voice_active), 64'h7f);
`ifdef VOICE_STEAL_EN
    // Ages after the retrigger: v0 oldest, then v1, then v3; v2 is skipped.
    note_on_to(7'd70, 0, 1'b0, "age70");
    note_on_to(7'd71, 1, 1'b0, "age71");
    note_on_to(7'd72, 3, 1'b0, "age72");
`endif

    // 6. Note-off 63, then a note-off with no matching voice
    do_reset();
    fill_60_66();
    send(1'b0, 7'd63, 1'b0, t_or, t_cnt, o_cnt);
    exp_active[3] = 1'b0;
    check("off63_active", 64'(voice_active), 64'b1110111);
    check("off63_trig",   64'(t_or),  64'd0);
    check("off63_ovf",    64'(o_cnt), 64'd0);
    check_table("off63");
    send(1'b0, 7'd99, 1'b0, t_or, t_cnt, o_cnt);
    check("off99_trig", 64'(t_or),  64'd0);
    check("off99_ovf",  64'(o_cnt), 64'd0);
    check_table("off99");
    // The freed voice is the only free one, so it takes the next note-on.
    note_on_to(7'd80, 3, 1'b0, "on80");

    // 7. Reset in the middle of a scan
    @(negedge clk);
    note_valid = 1'b1;
    note_on    = 1'b1;
    note       = 7'd10;
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midscan_busy", 64'(note_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    exp_active = '0;
    for (int v = 0; v < V; v++) exp_note[v] = '0;
    check("midrst_ready", 64'(note_ready), 64'd1);
    check("midrst_trig",  64'(voice_trig), 64'd0);
    check("midrst_ovf",   64'(overflow),   64'd0);
    check_table("midrst");
    note_on_to(7'd50, 0, 1'b0, "on50");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Converts a serial stream of note-on/note-off events into per-voice oscillator assignments for an OSC_VOICES polyphonic synth.
- Output voice_active_o is the active-voice word that feeds the downstream bitcount stage, which uses the count for mix normalisation.
- Performs free-voice search and oldest-voice stealing with a sequential scan, one voice per clock.

Parameters:
OSC_VOICES, 7, number of oscillator voices (2..16)
NOTE_W, 7, note number width
RANK_W, $clog2(OSC_VOICES), age-rank width (derived, not overridden)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
note_valid_i  input  1  event valid
note_ready_o  output  1  allocator can accept an event
note_on_i  input  1  1 = note-on, 0 = note-off
note_i  input  NOTE_W  note number
voice_active_o  output  OSC_VOICES  bit v = voice v sounding (to bitcount word_i)
voice_note_o  output  OSC_VOICES*NOTE_W  note of voice v at bits [v*NOTE_W +: NOTE_W]
voice_trig_o  output  OSC_VOICES  one-cycle pulse: voice v (re)started, oscillator phase reset
overflow_o  output  1  one-cycle pulse: note-on dropped (see optional feature)

Behaviour:
- One clock, clk_i; reset rst_i is synchronous and active-high. Reset forces IDLE; all outputs read 0 except note_ready_o, which reads 1 in the first cycle after reset; rank[v] = v. Reset mid-scan abandons the event with no output change other than the reset values.
- FSM: IDLE -> SCAN -> COMMIT -> IDLE.
- note_ready_o = (state == IDLE). An event is accepted on a clock edge where note_valid_i & note_ready_o; note_on_i and note_i are latched at that edge.
- SCAN lasts exactly OSC_VOICES cycles, examining voice index 0..OSC_VOICES-1 in order. It records:
  - first active voice whose note equals the latched note (match)
  - lowest-index inactive voice (free)
  - active voice with rank == OSC_VOICES-1 (oldest)
- COMMIT lasts 1 cycle. All output registers update on the edge leaving COMMIT. Ready is low for exactly OSC_VOICES+1 cycles after acceptance.
- Note-on priority: match > free > oldest (steal).
  - Target voice gets active=1, note=latched note, trig pulse.
  - Rank update: target rank becomes 0; every voice whose rank < the old target rank increments; others are unchanged. Ranks remain a permutation of 0..OSC_VOICES-1.
- Note-off: the matching voice gets active=0; its note is retained and ranks are unchanged. No match is a silent no-op (no trig, no overflow).
- voice_trig_o and overflow_o are high for exactly one cycle; all other outputs hold between events.
- Duplicate notes can never coexist, because a repeated note-on retriggers the existing voice.
- note_valid_i held high with ready low: the event is not consumed and must be held stable by the upstream stage.

Optional Feature:
VOICE_STEAL_EN
- Defined: when no match and no free voice exists, the oldest voice is stolen as described; overflow_o stays constant 0.
- Undefined: the note-on is dropped, overflow_o pulses for 1 cycle on the COMMIT exit edge, and no voice, note, or rank state changes.

Test Plan:
- Reset, then note-on 60 -> ready low 8 cycles (OSC_VOICES=7); then voice_active_o=7'b0000001, voice_note_o[6:0]=60, voice_trig_o[0] pulse 1 cycle.
- Note-ons 60..66 back-to-back with valid held -> voice_active_o=7'b1111111, voice v holds note 60+v, one trig per event, each acceptance spaced 8 cycles.
- With 7 voices full, note-on 70 and VOICE_STEAL_EN defined -> voice 0 takes note 70 with trig[0]; the next note-on 71 steals voice 1. Same case with the macro undefined -> overflow_o pulses, state unchanged.
- Note-on 62 while 62 sounds on voice 2 -> trig[2] pulse, voice_active_o unchanged, voice 2 becomes youngest (the next steal skips it).
- Note-off 63 with voices 0..6 active -> voice_active_o=7'b1110111, no trig; then note-off 99 -> no change.
- rst_i asserted mid-SCAN -> the following cycle shows all outputs 0 and ready=1; a new note-on 50 lands on voice 0.
